pe_spad_stream_loader: RTL

//  Transmit side of the PE scratchpad load interface. Per load command it reads compressed (CSC) iact and weight

---
 rtl/pe_load_pkg.sv | 27 ++
 rtl/pe_spad_stream_loader_if.sv | 43 ++++
 rtl/pe_csc_channel_tx.sv | 125 ++++++++++++
 rtl/pe_spad_stream_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pe_load_pkg.sv
// Shared encodings and operand widths for the PE scratchpad stream loader.
package pe_load_pkg;

  localparam int unsigned IACT_ADDR_W = 8;
  localparam int unsigned IACT_DATA_W = 13;
  localparam int unsigned WGHT_ADDR_W = 7;
  localparam int unsigned WGHT_DATA_W = 12;

  localparam logic TAG_ADDR = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  typedef enum logic [2:0] {
    TOP_IDLE,
    TOP_CLEAR,
    TOP_STREAM,
    TOP_WAIT_FIN,
    TOP_DONE
  } top_state_e;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_ADDR,
    CH_DATA,
    CH_DRAIN
  } ch_state_e;

endpackage

// File: rtl/pe_spad_stream_loader_if.sv
// Buffer read ports plus the PE scratchpad write side, as seen by the loader.
interface pe_spad_stream_loader_if
  import pe_load_pkg::*;
#(
  parameter int unsigned MEM_AW = 10
);

  logic                   iact_rd_en;
  logic [MEM_AW-1:0]      iact_rd_addr;
  logic [IACT_DATA_W-1:0] iact_rd_data;
  logic                   wght_rd_en;
  logic [MEM_AW-1:0]      wght_rd_addr;
  logic [WGHT_DATA_W-1:0] wght_rd_data;

  logic                   iact_address_in_valid;
  logic [IACT_ADDR_W-1:0] iact_address_in;
  logic                   iact_data_in_valid;
  logic [IACT_DATA_W-1:0] iact_data_in;
  logic                   weight_address_in_valid;
  logic [WGHT_ADDR_W-1:0] weight_address_in;
  logic                   weight_data_in_valid;
  logic [WGHT_DATA_W-1:0] weight_data_in;
  logic                   iact_write_fin_clear;
  logic                   weight_write_fin_clear;
  logic                   all_write_fin;

  modport master (
    output iact_rd_en, iact_rd_addr, wght_rd_en, wght_rd_addr,
    output iact_address_in_valid, iact_address_in, iact_data_in_valid, iact_data_in,
    output weight_address_in_valid, weight_address_in, weight_data_in_valid, weight_data_in,
    output iact_write_fin_clear, weight_write_fin_clear,
    input  iact_rd_data, wght_rd_data, all_write_fin
  );

  modport slave (
    input  iact_rd_en, iact_rd_addr, wght_rd_en, wght_rd_addr,
    input  iact_address_in_valid, iact_address_in, iact_data_in_valid, iact_data_in,
    input  weight_address_in_valid, weight_address_in, weight_data_in_valid, weight_data_in,
    input  iact_write_fin_clear, weight_write_fin_clear,
    output iact_rd_data, wght_rd_data, all_write_fin
  );

endinterface

// File: rtl/pe_csc_channel_tx.sv
// One CSC operand channel: reads the address vector then the data vector and
// forwards each returned word to the matching PE port two cycles after its read.
module pe_csc_channel_tx
  import pe_load_pkg::*;
#(
  parameter int unsigned MEM_AW     = 10,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned ADDR_OUT_W = 8,
  parameter int unsigned DATA_W     = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_AW-1:0]     base,
  input  logic [LEN_W-1:0]      addr_len,
  input  logic [LEN_W-1:0]      data_len,
  output logic                  rd_en,
  output logic [MEM_AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  addr_valid,
  output logic [ADDR_OUT_W-1:0] addr_out,
  output logic                  data_valid,
  output logic [DATA_W-1:0]     data_out,
  output logic                  idle_c
);

  ch_state_e             state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [MEM_AW-1:0]     rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  tag_q, tag_d;
  logic                  vld_p_q, vld_p_d;
  logic                  tag_p_q, tag_p_d;
  logic                  addr_valid_q, addr_valid_d;
  logic [ADDR_OUT_W-1:0] addr_out_q, addr_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;

  // rd_en_q/rd_addr_q/tag_q describe the read issued in the current cycle.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    case (state_q)
      CH_IDLE: if (start) begin
        if (addr_len != '0) begin
          state_d = CH_ADDR; rd_en_d = 1'b1; rd_addr_d = base;
          cnt_d = LEN_W'(addr_len - 1'b1); tag_d = TAG_ADDR;
        end else if (data_len != '0) begin
          state_d = CH_DATA; rd_en_d = 1'b1; rd_addr_d = base;
          cnt_d = LEN_W'(data_len - 1'b1); tag_d = TAG_DATA;
        end else begin
          state_d = CH_DRAIN;
        end
      end
      CH_ADDR: begin
        if (cnt_q != '0) begin
          rd_en_d = 1'b1; rd_addr_d = MEM_AW'(rd_addr_q + 1'b1);
          cnt_d = LEN_W'(cnt_q - 1'b1);
        end else if (data_len != '0) begin
          state_d = CH_DATA; rd_en_d = 1'b1; rd_addr_d = MEM_AW'(rd_addr_q + 1'b1);
          cnt_d = LEN_W'(data_len - 1'b1); tag_d = TAG_DATA;
        end else begin
          state_d = CH_DRAIN;
        end
      end
      CH_DATA: begin
        if (cnt_q != '0) begin
          rd_en_d = 1'b1; rd_addr_d = MEM_AW'(rd_addr_q + 1'b1);
          cnt_d = LEN_W'(cnt_q - 1'b1);
        end else begin
          state_d = CH_DRAIN;
        end
      end
      CH_DRAIN: state_d = CH_IDLE;
      default:  state_d = CH_IDLE;
    endcase

    vld_p_d      = rd_en_q;
    tag_p_d      = tag_q;
    addr_valid_d = vld_p_q && (tag_p_q == TAG_ADDR);
    data_valid_d = vld_p_q && (tag_p_q == TAG_DATA);
    addr_out_d   = addr_valid_d ? rd_data[ADDR_OUT_W-1:0] : addr_out_q;
    data_out_d   = data_valid_d ? rd_data : data_out_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= CH_IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      cnt_q        <= '0;
      tag_q        <= TAG_ADDR;
      vld_p_q      <= 1'b0;
      tag_p_q      <= TAG_ADDR;
      addr_valid_q <= 1'b0;
      addr_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      vld_p_q      <= vld_p_d;
      tag_p_q      <= tag_p_d;
      addr_valid_q <= addr_valid_d;
      addr_out_q   <= addr_out_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign addr_valid = addr_valid_q;
  assign addr_out   = addr_out_q;
  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;
  assign idle_c     = (state_q == CH_IDLE);

endmodule

// File: rtl/pe_spad_stream_loader.sv
// Per load command: clears the PE write-fins of reloaded operands, streams the
// selected CSC vectors into the PE, then waits for all_write_fin before done.
module pe_spad_stream_loader
  import pe_load_pkg::*;
#(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_iact,
  input  logic              load_weight,
  input  logic [MEM_AW-1:0] iact_base,
  input  logic [LEN_W-1:0]  iact_addr_len,
  input  logic [LEN_W-1:0]  iact_data_len,
  input  logic [MEM_AW-1:0] wght_base,
  input  logic [LEN_W-1:0]  wght_addr_len,
  input  logic [LEN_W-1:0]  wght_data_len,
  pe_spad_stream_loader_if.master bus,
  output logic              busy,
  output logic              done
);

  top_state_e        state_q, state_d;
  logic              load_iact_q, load_iact_d, load_weight_q, load_weight_d;
  logic [MEM_AW-1:0] iact_base_q, iact_base_d, wght_base_q, wght_base_d;
  logic [LEN_W-1:0]  iact_alen_q, iact_alen_d, iact_dlen_q, iact_dlen_d;
  logic [LEN_W-1:0]  wght_alen_q, wght_alen_d, wght_dlen_q, wght_dlen_d;
  logic              fin_seen_q, fin_seen_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              iact_clr_q, iact_clr_d, wght_clr_q, wght_clr_d;
  logic              iact_start_c, wght_start_c, iact_idle_c, wght_idle_c;

  always_comb begin
    state_d       = state_q;
    load_iact_d   = load_iact_q;
    load_weight_d = load_weight_q;
    iact_base_d   = iact_base_q;
    iact_alen_d   = iact_alen_q;
    iact_dlen_d   = iact_dlen_q;
    wght_base_d   = wght_base_q;
    wght_alen_d   = wght_alen_q;
    wght_dlen_d   = wght_dlen_q;
    fin_seen_d    = fin_seen_q;
    iact_clr_d    = 1'b0;
    wght_clr_d    = 1'b0;
    case (state_q)
      TOP_IDLE: begin
        fin_seen_d = 1'b0;
        if (start) begin
          state_d       = TOP_CLEAR;
          load_iact_d   = load_iact;
          load_weight_d = load_weight;
          iact_base_d   = iact_base;
          iact_alen_d   = iact_addr_len;
          iact_dlen_d   = iact_data_len;
          wght_base_d   = wght_base;
          wght_alen_d   = wght_addr_len;
          wght_dlen_d   = wght_data_len;
          iact_clr_d    = load_iact;
          wght_clr_d    = load_weight;
        end
      end
      TOP_CLEAR: state_d = TOP_STREAM;
      // A fin seen while streaming is remembered so WAIT_FIN can leave at once.
      TOP_STREAM: begin
        if (bus.all_write_fin) fin_seen_d = 1'b1;
        if (iact_idle_c && wght_idle_c) state_d = TOP_WAIT_FIN;
      end
      TOP_WAIT_FIN: if (bus.all_write_fin || fin_seen_q) state_d = TOP_DONE;
      TOP_DONE:     state_d = TOP_IDLE;
      default:      state_d = TOP_IDLE;
    endcase
    busy_d = (state_d != TOP_IDLE);
    done_d = (state_d == TOP_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= TOP_IDLE;
      load_iact_q   <= 1'b0;
      load_weight_q <= 1'b0;
      iact_base_q   <= '0;
      iact_alen_q   <= '0;
      iact_dlen_q   <= '0;
      wght_base_q   <= '0;
      wght_alen_q   <= '0;
      wght_dlen_q   <= '0;
      fin_seen_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      iact_clr_q    <= 1'b0;
      wght_clr_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_iact_q   <= load_iact_d;
      load_weight_q <= load_weight_d;
      iact_base_q   <= iact_base_d;
      iact_alen_q   <= iact_alen_d;
      iact_dlen_q   <= iact_dlen_d;
      wght_base_q   <= wght_base_d;
      wght_alen_q   <= wght_alen_d;
      wght_dlen_q   <= wght_dlen_d;
      fin_seen_q    <= fin_seen_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      iact_clr_q    <= iact_clr_d;
      wght_clr_q    <= wght_clr_d;
    end
  end

  // Channels launch on the CLEAR->STREAM edge so their first read lands in STREAM.
  assign iact_start_c = (state_q == TOP_CLEAR) && load_iact_q;
  assign wght_start_c = (state_q == TOP_CLEAR) && load_weight_q;

  pe_csc_channel_tx #(
    .MEM_AW(MEM_AW), .LEN_W(LEN_W), .ADDR_OUT_W(IACT_ADDR_W), .DATA_W(IACT_DATA_W)
  ) u_iact (
    .clock     (clock),
    .reset     (reset),
    .start     (iact_start_c),
    .base      (iact_base_q),
    .addr_len  (iact_alen_q),
    .data_len  (iact_dlen_q),
    .rd_en     (bus.iact_rd_en),
    .rd_addr   (bus.iact_rd_addr),
    .rd_data   (bus.iact_rd_data),
    .addr_valid(bus.iact_address_in_valid),
    .addr_out  (bus.iact_address_in),
    .data_valid(bus.iact_data_in_valid),
    .data_out  (bus.iact_data_in),
    .idle_c    (iact_idle_c)
  );

  pe_csc_channel_tx #(
    .MEM_AW(MEM_AW), .LEN_W(LEN_W), .ADDR_OUT_W(WGHT_ADDR_W), .DATA_W(WGHT_DATA_W)
  ) u_wght (
    .clock     (clock),
    .reset     (reset),
    .start     (wght_start_c),
    .base      (wght_base_q),
    .addr_len  (wght_alen_q),
    .data_len  (wght_dlen_q),
    .rd_en     (bus.wght_rd_en),
    .rd_addr   (bus.wght_rd_addr),
    .rd_data   (bus.wght_rd_data),
    .addr_valid(bus.weight_address_in_valid),
    .addr_out  (bus.weight_address_in),
    .data_valid(bus.weight_data_in_valid),
    .data_out  (bus.weight_data_in),
    .idle_c    (wght_idle_c)
  );

  assign bus.iact_write_fin_clear   = iact_clr_q;
  assign bus.weight_write_fin_clear = wght_clr_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
